// File: rtl/grf_wb_ctrl.sv
// Register-file write-port arbiter: ALU writebacks, buffered load
// writebacks and a pending-load scoreboard for read-hazard detection.
module grf_wb_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_b,
  input  logic        i_clk_en,
  input  logic        i_alu_valid,
  input  logic [3:0]  i_alu_waddr,
  input  logic [31:0] i_alu_data,
  input  logic        i_mem_valid,
  input  logic [3:0]  i_mem_waddr,
  input  logic [3:0]  i_mem_wen,
  input  logic [31:0] i_mem_data,
  output logic        o_mem_ready,
  input  logic        i_iss_valid,
  input  logic [3:0]  i_iss_waddr,
  input  logic [3:0]  i_chk_raddr_0,
  input  logic [3:0]  i_chk_raddr_1,
  output logic        o_hazard_0,
  output logic        o_hazard_1,
  output logic [3:0]  o_rf_waddr,
  output logic [3:0]  o_rf_wen,
  output logic [31:0] o_rf_din,
  output logic        o_rf_cs_b
);

  typedef struct packed {
    logic [3:0]  waddr;
    logic [3:0]  wen;
    logic [31:0] data;
  } ld_t;

  ld_t         fifo_q [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [15:0] pending;

  logic        mem_acc;
  logic        sel_fifo;
  logic        sel_byp;
  logic        sel_ld;
  logic        enq;
  logic        deq;
  ld_t         in_ld;
  ld_t         ld_sel;
  logic [15:0] clr_vec;
  logic [15:0] set_vec;
  logic [15:0] pend_nxt;
  logic [1:0]  count_nxt;

  assign o_mem_ready = (count != 2'd2);
  assign mem_acc     = i_mem_valid & o_mem_ready;

  assign in_ld = '{
    waddr: i_mem_waddr,
    wen:   i_mem_wen,
    data:  i_mem_data
  };

  // ALU always wins; the oldest load goes next, bypassing an empty FIFO.
  assign sel_fifo = !i_alu_valid && (count != 2'd0);
  assign sel_byp  = !i_alu_valid && (count == 2'd0) && mem_acc;
  assign sel_ld   = sel_fifo | sel_byp;
  assign deq      = sel_fifo;
  assign enq      = mem_acc & ~sel_byp;
  assign ld_sel   = sel_fifo ? fifo_q[rd_ptr] : in_ld;

  assign count_nxt = count + {1'b0, enq} - {1'b0, deq};

  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (sel_ld)
      clr_vec = 16'd1 << ld_sel.waddr;
    if (i_iss_valid)
      set_vec = 16'd1 << i_iss_waddr;
  end

  // A new issue on the same edge outlives the clear of the old load.
  assign pend_nxt = (pending & ~clr_vec) | set_vec;

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      pending   <= '0;
    end else if (i_clk_en) begin
      if (enq) begin
        fifo_q[wr_ptr] <= in_ld;
        wr_ptr         <= ~wr_ptr;
      end
      if (deq)
        rd_ptr <= ~rd_ptr;
      count   <= count_nxt;
      pending <= pend_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      o_rf_cs_b  <= 1'b1;
      o_rf_wen   <= 4'h0;
      o_rf_waddr <= 4'h0;
      o_rf_din   <= 32'h0;
    end else if (i_clk_en) begin
      unique case (1'b1)
        i_alu_valid: begin
          o_rf_cs_b  <= 1'b0;
          o_rf_wen   <= 4'hF;
          o_rf_waddr <= i_alu_waddr;
          o_rf_din   <= i_alu_data;
        end
        sel_ld: begin
          o_rf_cs_b  <= 1'b0;
          o_rf_wen   <= ld_sel.wen;
          o_rf_waddr <= ld_sel.waddr;
          o_rf_din   <= ld_sel.data;
        end
        default: begin
          o_rf_cs_b <= 1'b1;
          o_rf_wen  <= 4'h0;
        end
      endcase
    end
  end

  // The register file has no write-through, so an in-flight write is a hazard.
  assign o_hazard_0 = pending[i_chk_raddr_0] |
                      (!o_rf_cs_b && (o_rf_waddr == i_chk_raddr_0));
  assign o_hazard_1 = pending[i_chk_raddr_1] |
                      (!o_rf_cs_b && (o_rf_waddr == i_chk_raddr_1));

endmodule

// File: tb/tb_grf_wb_ctrl.sv
// Bench for grf_wb_ctrl: directed scenarios plus random traffic
// compared against a queue-based writeback model.
module tb_grf_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        clk_en;
  logic        alu_valid;
  logic [3:0]  alu_waddr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [3:0]  mem_waddr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        iss_valid;
  logic [3:0]  iss_waddr;
  logic [3:0]  raddr0;
  logic [3:0]  raddr1;
  logic        hz0;
  logic        hz1;
  logic [3:0]  rf_waddr;
  logic [3:0]  rf_wen;
  logic [31:0] rf_din;
  logic        rf_cs_b;

  int errors = 0;
  int checks = 0;

  // Model state: visible write port, queue of waiting loads, pending set.
  logic        m_cs_b;
  logic [3:0]  m_wen;
  logic [3:0]  m_waddr;
  logic [31:0] m_din;
  logic [39:0] m_q [$];
  logic [15:0] m_pend;

  grf_wb_ctrl dut (
    .i_clk         (clk),
    .i_rst_b       (rst_b),
    .i_clk_en      (clk_en),
    .i_alu_valid   (alu_valid),
    .i_alu_waddr   (alu_waddr),
    .i_alu_data    (alu_data),
    .i_mem_valid   (mem_valid),
    .i_mem_waddr   (mem_waddr),
    .i_mem_wen     (mem_wen),
    .i_mem_data    (mem_data),
    .o_mem_ready   (mem_ready),
    .i_iss_valid   (iss_valid),
    .i_iss_waddr   (iss_waddr),
    .i_chk_raddr_0 (raddr0),
    .i_chk_raddr_1 (raddr1),
    .o_hazard_0    (hz0),
    .o_hazard_1    (hz1),
    .o_rf_waddr    (rf_waddr),
    .o_rf_wen      (rf_wen),
    .o_rf_din      (rf_din),
    .o_rf_cs_b     (rf_cs_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [40:0] exp_out();
    return {m_cs_b, m_wen, m_waddr, m_din};
  endfunction

  function automatic logic exp_hz(input logic [3:0] r);
    return m_pend[r] | (!m_cs_b && m_waddr == r);
  endfunction

  task automatic model_clear();
    m_cs_b  = 1'b1;
    m_wen   = 4'h0;
    m_waddr = 4'h0;
    m_din   = 32'h0;
    m_q     = {};
    m_pend  = '0;
  endtask

  // Oldest available load (queued or arriving now) is written unless ALU.
  task automatic model_edge();
    logic [39:0] pool [$];
    logic [39:0] e;
    if (!rst_b || !clk_en) return;
    pool = m_q;
    if (mem_valid && m_q.size() < 2)
      pool.push_back({mem_waddr, mem_wen, mem_data});
    if (alu_valid) begin
      m_cs_b = 1'b0; m_wen = 4'hF;
      m_waddr = alu_waddr; m_din = alu_data;
    end else if (pool.size() > 0) begin
      e = pool.pop_front();
      m_cs_b = 1'b0; m_waddr = e[39:36];
      m_wen = e[35:32]; m_din = e[31:0];
      m_pend[e[39:36]] = 1'b0;
    end else begin
      m_cs_b = 1'b1; m_wen = 4'h0;
    end
    if (iss_valid) m_pend[iss_waddr] = 1'b1;
    m_q = pool;
  endtask

  task automatic idle_inputs();
    clk_en = 1'b1;
    alu_valid = 1'b0; alu_waddr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_waddr = '0;
    mem_wen = '0; mem_data = '0;
    iss_valid = 1'b0; iss_waddr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_b = 1'b0;
    model_clear();
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    raddr0 = 4'd0; raddr1 = 4'd15;
    #1;
    checks++;
    if ({rf_cs_b, rf_wen, rf_waddr, rf_din} !== {1'b1, 40'h0}) begin
      errors++;
      $display("FAIL reset_out got=%h want=%h",
        {rf_cs_b, rf_wen, rf_waddr, rf_din}, {1'b1, 40'h0});
    end
    checks++;
    if ({mem_ready, hz0, hz1} !== 3'b100) begin
      errors++;
      $display("FAIL reset_rdy_hz got=%b want=100",
        {mem_ready, hz0, hz1});
    end
  endtask

  task automatic test_alu();
    do_reset();
    raddr0 = 4'd3; raddr1 = 4'd4;
    alu_valid = 1'b1; alu_waddr = 4'd3;
    alu_data = 32'h12345678;
    tick();
    idle_inputs();
    checks++;
    if ({rf_cs_b, rf_wen, rf_waddr, rf_din} !==
        {1'b0, 4'hF, 4'd3, 32'h12345678}) begin
      errors++;
      $display("FAIL alu_write got=%h want=%h",
        {rf_cs_b, rf_wen, rf_waddr, rf_din},
        {1'b0, 4'hF, 4'd3, 32'h12345678});
    end
    checks++;
    if (hz0 !== 1'b1 || hz1 !== 1'b0) begin
      errors++;
      $display("FAIL alu_hz got=%b%b want=10", hz0, hz1);
    end
    tick();
    checks++;
    if (rf_cs_b !== 1'b1 || rf_wen !== 4'h0) begin
      errors++;
      $display("FAIL alu_idle got=%b/%h want=1/0", rf_cs_b, rf_wen);
    end
  endtask

  task automatic test_load_hazard();
    do_reset();
    raddr0 = 4'd5; raddr1 = 4'd6;
    iss_valid = 1'b1; iss_waddr = 4'd5;
    tick();
    idle_inputs();
    checks++;
    if (hz0 !== 1'b1 || hz1 !== 1'b0) begin
      errors++;
      $display("FAIL ld_pend got=%b%b want=10", hz0, hz1);
    end
    mem_valid = 1'b1; mem_waddr = 4'd5;
    mem_wen = 4'b0011; mem_data = 32'h0000BEEF;
    #1;
    checks++;
    if (hz0 !== 1'b1 || mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL ld_pre got=%b%b want=11", hz0, mem_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if ({rf_cs_b, rf_wen, rf_waddr, rf_din} !==
        {1'b0, 4'b0011, 4'd5, 32'h0000BEEF}) begin
      errors++;
      $display("FAIL ld_write got=%h want=%h",
        {rf_cs_b, rf_wen, rf_waddr, rf_din},
        {1'b0, 4'b0011, 4'd5, 32'h0000BEEF});
    end
    checks++;
    if (hz0 !== 1'b1) begin
      errors++;
      $display("FAIL ld_hz_wr got=%b want=1", hz0);
    end
    tick();
    checks++;
    if (hz0 !== 1'b0 || rf_cs_b !== 1'b1) begin
      errors++;
      $display("FAIL ld_hz_after got=%b/%b want=0/1", hz0, rf_cs_b);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen [$];
    logic [3:0] want [7] = '{8, 9, 10, 11, 1, 2, 3};
    int ld = 0;
    do_reset();
    raddr0 = 4'd1; raddr1 = 4'd3;
    for (int c = 0; c < 12; c++) begin
      alu_valid = (c < 4);
      alu_waddr = 4'(8 + c);
      alu_data = $urandom;
      mem_valid = (ld < 3);
      mem_waddr = 4'(ld + 1);
      mem_wen = 4'hF;
      mem_data = $urandom;
      #1;
      if (c >= 2 && c <= 4) begin
        checks++;
        if (mem_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_full c=%0d got=%b want=0", c, mem_ready);
        end
      end
      if (mem_valid && mem_ready) ld++;
      tick();
      if (!rf_cs_b) seen.push_back(rf_waddr);
      checks++;
      if ({rf_cs_b, rf_wen, rf_waddr, rf_din} !== exp_out()) begin
        errors++;
        $display("FAIL b2b_out c=%0d got=%h want=%h", c,
          {rf_cs_b, rf_wen, rf_waddr, rf_din}, exp_out());
      end
    end
    idle_inputs();
    checks++;
    if (seen.size() != 7) begin
      errors++;
      $display("FAIL b2b_count got=%0d want=7", seen.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (seen[i] !== want[i]) begin
          errors++;
          $display("FAIL b2b_order i=%0d got=%0d want=%0d",
            i, seen[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    raddr0 = 4'd7; raddr1 = 4'd0;
    iss_valid = 1'b1; iss_waddr = 4'd7;
    tick();
    mem_valid = 1'b1; mem_waddr = 4'd7;
    mem_wen = 4'hC; mem_data = 32'hCAFE0000;
    tick();
    idle_inputs();
    checks++;
    if (rf_cs_b !== 1'b0 || rf_waddr !== 4'd7) begin
      errors++;
      $display("FAIL setwin_wr got=%b/%0d want=0/7", rf_cs_b, rf_waddr);
    end
    tick();
    checks++;
    if (rf_cs_b !== 1'b1 || hz0 !== 1'b1) begin
      errors++;
      $display("FAIL setwin_pend got=%b/%b want=1/1", rf_cs_b, hz0);
    end
  endtask

  task automatic test_clk_en();
    logic [40:0] snap;
    do_reset();
    raddr0 = 4'd9; raddr1 = 4'd14;
    alu_valid = 1'b1; alu_waddr = 4'd10; alu_data = 32'hA0A0A0A0;
    mem_valid = 1'b1; mem_waddr = 4'd9;
    mem_wen = 4'hF; mem_data = 32'h99999999;
    iss_valid = 1'b1; iss_waddr = 4'd9;
    tick();
    snap = {rf_cs_b, rf_wen, rf_waddr, rf_din};
    clk_en = 1'b0;
    alu_waddr = 4'd12; mem_waddr = 4'd13; iss_waddr = 4'd14;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({rf_cs_b, rf_wen, rf_waddr, rf_din} !==
          {1'b0, 4'hF, 4'd10, 32'hA0A0A0A0} ||
          {mem_ready, hz0, hz1} !== 3'b110) begin
        errors++;
        $display("FAIL clken_hold c=%0d got=%h/%b want=%h/110", c,
          {rf_cs_b, rf_wen, rf_waddr, rf_din},
          {mem_ready, hz0, hz1}, snap);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if ({rf_cs_b, rf_wen, rf_waddr, rf_din} !==
        {1'b0, 4'hF, 4'd9, 32'h99999999}) begin
      errors++;
      $display("FAIL clken_resume got=%h want=%h",
        {rf_cs_b, rf_wen, rf_waddr, rf_din},
        {1'b0, 4'hF, 4'd9, 32'h99999999});
    end
    tick();
    checks++;
    if ({rf_cs_b, hz0, hz1, mem_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL clken_single got=%b want=1001",
        {rf_cs_b, hz0, hz1, mem_ready});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    raddr0 = 4'd4; raddr1 = 4'd5;
    alu_valid = 1'b1; alu_waddr = 4'd2; alu_data = 32'h1;
    mem_valid = 1'b1; mem_waddr = 4'd5;
    mem_wen = 4'hF; mem_data = 32'h55;
    iss_valid = 1'b1; iss_waddr = 4'd4;
    tick();
    iss_valid = 1'b0;
    mem_waddr = 4'd6; mem_data = 32'h66;
    tick();
    checks++;
    if (mem_ready !== 1'b0 || hz0 !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got=%b%b want=01", mem_ready, hz0);
    end
    #2;
    rst_b = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({rf_cs_b, rf_wen, rf_waddr, rf_din} !== {1'b1, 40'h0} ||
        {mem_ready, hz0, hz1} !== 3'b100) begin
      errors++;
      $display("FAIL rstmid_async got=%h/%b want=%h/100",
        {rf_cs_b, rf_wen, rf_waddr, rf_din},
        {mem_ready, hz0, hz1}, {1'b1, 40'h0});
    end
    @(negedge clk);
    idle_inputs();
    rst_b = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (rf_cs_b !== 1'b1 || mem_ready !== 1'b1 || hz0 !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_stale c=%0d got=%b%b%b want=110",
          c, rf_cs_b, mem_ready, hz0);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      clk_en    = ($urandom_range(0, 99) < 85);
      alu_valid = ($urandom_range(0, 99) < 40);
      alu_waddr = 4'($urandom);
      alu_data  = $urandom;
      mem_valid = ($urandom_range(0, 99) < 50);
      mem_waddr = 4'($urandom);
      mem_wen   = 4'($urandom);
      mem_data  = $urandom;
      iss_valid = ($urandom_range(0, 99) < 30);
      iss_waddr = 4'($urandom);
      raddr0    = 4'($urandom);
      raddr1    = 4'($urandom);
      #1;
      checks++;
      if (mem_ready !== (m_q.size() < 2) ||
          hz0 !== exp_hz(raddr0) || hz1 !== exp_hz(raddr1)) begin
        errors++;
        $display("FAIL rnd_comb c=%0d got=%b%b%b want=%b%b%b", c,
          mem_ready, hz0, hz1, (m_q.size() < 2),
          exp_hz(raddr0), exp_hz(raddr1));
      end
      tick();
      checks++;
      if ({rf_cs_b, rf_wen, rf_waddr, rf_din} !== exp_out()) begin
        errors++;
        $display("FAIL rnd_out c=%0d got=%h want=%h", c,
          {rf_cs_b, rf_wen, rf_waddr, rf_din}, exp_out());
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_b = 1'b0;
    raddr0 = '0;
    raddr1 = '0;
    idle_inputs();
    model_clear();
    test_reset();
    test_alu();
    test_load_hazard();
    test_back_to_back();
    test_set_wins();
    test_clk_en();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
